seven_seg_scan_driver: RTL and testbench

//  Downstream consumer of the four BCD digit counters (HH:MM) in the alarm/clock.

---
 rtl/seven_seg_scan_driver.sv | 137 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexes four BCD digits (HH:MM) onto one common-anode 7-segment
//   display. Provides per-digit blink, leading-zero blanking of the hours-tens
//   digit and an all-anodes-off dead time at every digit change. The digit
//   inputs are captured once per frame, so a frame never mixes old and new
//   values.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   en           in   display enable (0 blanks the display; the scan keeps running)
//   digit0..3    in   BCD digits: minutes units, minutes tens, hours units, hours tens
//   blink_mask   in   bit i = 1 makes digit i blink (sampled live)
//   dp_mask      in   bit i = 1 lights the decimal point on digit i (sampled live)
//   blank_lead   in   1 blanks digit3 when its latched value is 0
//   an           out  anode selects, active-low, an[i] drives digit i
//   seg          out  segments {g,f,e,d,c,b,a}, active-low
//   dp           out  decimal point, active-low
//   frame_start  out  one-clock pulse when the scan wraps back to digit 0
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int BT_W = $clog2(BLINK_TICKS + 1);
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(REFRESH_DIV - 1);
  localparam logic [RC_W-1:0] DEAD_LAST = RC_W'(DEAD_CYCLES - 1);
  localparam logic [BT_W-1:0] BT_LAST   = BT_W'(BLINK_TICKS - 1);
  localparam logic [6:0]      SEG_OFF   = 7'h7F;

  typedef enum logic {
    ST_DEAD,
    ST_DRIVE
  } state_t;

  // Active-low gfedcba pattern; codes above 9 stay dark rather than show garbage.
  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Stage p0: scan timing, FSM, blink phase and frame shadow
  logic [RC_W-1:0]  rc_p0;
  logic [1:0]       idx_p0;
  state_t           state_p0;
  logic [BT_W-1:0]  bcnt_p0;
  logic             phase_p0;
  logic [3:0][3:0]  shadow_p0;

  logic             tick;
  logic [3:0]       cur_digit;
  logic             blank_digit;

  assign tick      = (rc_p0 == RC_LAST);
  assign cur_digit = shadow_p0[idx_p0];
  // Blink outranks leading blank; both keep the anode asserted.
  assign blank_digit = (phase_p0 && blink_mask[idx_p0]) ||
                       (idx_p0 == 2'd3 && blank_lead && shadow_p0[3] == 4'd0);

  // Stage p1: registered display outputs, one clock behind stage p0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc_p0       <= '0;
      idx_p0      <= 2'd0;
      state_p0    <= ST_DEAD;
      bcnt_p0     <= '0;
      phase_p0    <= 1'b0;
      shadow_p0   <= '0;
      an          <= 4'hF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        rc_p0    <= '0;
        idx_p0   <= idx_p0 + 2'd1;
        state_p0 <= ST_DEAD;
        if (idx_p0 == 2'd3) begin
          shadow_p0   <= {digit3, digit2, digit1, digit0};
          frame_start <= 1'b1;
        end
        if (bcnt_p0 == BT_LAST) begin
          bcnt_p0  <= '0;
          phase_p0 <= ~phase_p0;
        end else begin
          bcnt_p0 <= bcnt_p0 + 1'b1;
        end
      end else begin
        rc_p0 <= rc_p0 + 1'b1;
        if (state_p0 == ST_DEAD && rc_p0 == DEAD_LAST)
          state_p0 <= ST_DRIVE;
      end

      if (!en || state_p0 == ST_DEAD) begin
        an  <= 4'hF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx_p0);
        seg <= blank_digit ? SEG_OFF : decode_bcd(cur_digit);
        dp  <= blank_digit ? 1'b1 : ~dp_mask[idx_p0];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  localparam int R  = 4;
  localparam int D  = 1;
  localparam int BT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] blink_mask, dp_mask;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int vectors     = 0;
  int miscompares = 0;

  seven_seg_scan_driver #(
    .REFRESH_DIV(R),
    .DEAD_CYCLES(D),
    .BLINK_TICKS(BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: m counts clock edges since reset release; every scan
  // quantity follows from m by division, and the shadow is refreshed every
  // 4*R edges from whatever the digit inputs hold at that moment.
  int   m;
  int   sh[4];
  int   m_rc, m_slot, m_idx, m_phase;
  logic m_blank;
  exp_t m_e;

  always @(posedge clk) begin
    m_e.an  = 4'hF;
    m_e.seg = 7'h7F;
    m_e.dp  = 1'b1;
    m_e.fs  = 1'b0;
    if (!rst) begin
      m = 0;
      for (int i = 0; i < 4; i++) sh[i] = 0;
    end else begin
      m_rc    = m % R;
      m_slot  = m / R;
      m_idx   = m_slot % 4;
      m_phase = (m_slot / BT) % 2;
      if (en && m_rc >= D) begin
        m_e.an  = 4'hF;
        m_e.an[m_idx] = 1'b0;
        m_blank = (m_phase == 1 && blink_mask[m_idx]) ||
                  (m_idx == 3 && blank_lead && sh[3] == 0);
        m_e.seg = m_blank ? 7'h7F : seg_of(sh[m_idx]);
        m_e.dp  = m_blank ? 1'b1 : !dp_mask[m_idx];
      end
      m++;
      if (m % (4 * R) == 0) begin
        sh[0] = int'(digit0);
        sh[1] = int'(digit1);
        sh[2] = int'(digit2);
        sh[3] = int'(digit3);
        m_e.fs = 1'b1;
      end
    end
    exp_q.push_back(m_e);
  end

  // Monitor: one expected record per clock, compared mid-cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp || frame_start !== mon_e.fs) begin
        miscompares++;
        $display("FAIL scan t=%0t got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                 $time, an, seg, dp, frame_start, mon_e.an, mon_e.seg, mon_e.dp, mon_e.fs);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  initial begin
    bit seen;
    rst = 1'b0;
    en = 1'b1;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;
    blank_lead = 1'b0;
    run(3);
    rst = 1'b1;

    // 0000 frame, then 1,2,3,4 frames
    run(40);

    // digit0 5 -> 6 in the middle of a frame
    digit0 = 4'd5;
    run(16 + 8);
    digit0 = 4'd6;
    run(32);

    // blink on digit0
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    blink_mask = 4'b0001;
    run(64);
    blink_mask = 4'b0000;

    // leading blank on and off
    digit3 = 4'd0;
    blank_lead = 1'b1;
    run(32);
    blank_lead = 1'b0;
    run(32);

    // out-of-range digit with decimal point
    digit1  = 4'hC;
    dp_mask = 4'b0010;
    run(32);

    // display disabled for one frame, then resumed mid-frame
    en = 1'b0;
    run(16);
    en = 1'b1;
    run(6);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(20);

    // asynchronous reset inside a DRIVE slot
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (frame_start === 1'b1);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL frame_wait got no frame_start within 40 clk, want a pulse");
    end
    run(2);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst got an=%b seg=%h dp=%b fs=%b, want an=1111 seg=7f dp=1 fs=0",
               an, seg, dp, frame_start);
    end
    run(2);
    rst = 1'b1;
    run(40);

    // randomized stimulus
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 2) == 0) digit3 = 4'd0;
      end
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dp_mask    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lead = 1'($urandom);
      if ($urandom_range(0, 31) == 0) en         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #3;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    en = 1'b1;
    run(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
